argmax_wake: RTL and testbench

ARGMAX_WAKE -- requirements
Module: argmax_wake

---
 rtl/wrd_pkg.sv | 25 ++
 rtl/wake_debounce.sv | 81 ++++++++
 rtl/argmax_wake.sv | 128 ++++++++++++
 tb/tb_argmax_wake.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/wrd_pkg.sv
// rtl/wrd_pkg.sv - shared FSM encoding and width helpers for the argmax wake detector
// Contents:
//   state_e  : frame FSM states (ACCUM collects scores, DECIDE resolves the frame)
//   class_bw : width of a class index, max(1, clog2(n))
//   cnt_bw   : width of a counter that must hold 0..n, max(1, clog2(n+1))
package wrd_pkg;

  typedef enum logic {
    ST_ACCUM  = 1'b0,
    ST_DECIDE = 1'b1
  } state_e;

  function automatic int class_bw(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int cnt_bw(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/wake_debounce.sv
// rtl/wake_debounce.sv - N-of-M hit history with post-wake holdoff and wake pulse stretcher
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   decide_i       : one-cycle strobe for each well-formed frame decision
//   class_i        : argmax of the frame being decided
//   target_i       : class index that counts as a hit (sampled with decide_i)
//   wake_o         : wake pulse, WAKE_CYCLES long, starts the cycle after a trigger
module wake_debounce
  import wrd_pkg::*;
#(
  parameter int NUM_CLASSES    = 3,
  parameter int HIST_LEN       = 4,
  parameter int HIT_THRESH     = 3,
  parameter int WAKE_CYCLES    = 16,
  parameter int HOLDOFF_FRAMES = 8,
  localparam int CLASS_BW      = class_bw(NUM_CLASSES)
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                decide_i,
  input  logic [CLASS_BW-1:0] class_i,
  input  logic [CLASS_BW-1:0] target_i,
  output logic                wake_o
);

  localparam int POP_W   = cnt_bw(HIST_LEN);
  localparam int HO_W    = cnt_bw(HOLDOFF_FRAMES);
  localparam int PULSE_W = cnt_bw(WAKE_CYCLES);

  logic [HIST_LEN-1:0] hist_q, hist_d, hist_shift;
  logic [HO_W-1:0]     holdoff_q, holdoff_d;
  logic [PULSE_W-1:0]  pulse_q, pulse_d;
  logic [POP_W-1:0]    pop;
  logic                hit, trigger;

  always_comb begin
    // A target index outside the class range can never match a real argmax.
    hit        = (class_i == target_i) && (int'(target_i) < NUM_CLASSES);
    hist_shift = (hist_q << 1) | HIST_LEN'(hit);

    pop = '0;
    for (int i = 0; i < HIST_LEN; i++) begin
      pop = pop + POP_W'(hist_shift[i]);
    end

    trigger = decide_i && (holdoff_q == '0) && (int'(pop) >= HIT_THRESH);

    hist_d    = hist_q;
    holdoff_d = holdoff_q;
    pulse_d   = (pulse_q != '0) ? pulse_q - PULSE_W'(1) : pulse_q;

    if (decide_i) begin
      if (holdoff_q != '0) begin
        // Frames during holdoff are consumed without touching the history.
        holdoff_d = holdoff_q - HO_W'(1);
      end else if (trigger) begin
        hist_d    = '0;
        holdoff_d = HO_W'(HOLDOFF_FRAMES);
        // Reload also covers a retrigger while the pulse is still running.
        pulse_d   = PULSE_W'(WAKE_CYCLES);
      end else begin
        hist_d = hist_shift;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hist_q    <= '0;
      holdoff_q <= '0;
      pulse_q   <= '0;
    end else begin
      hist_q    <= hist_d;
      holdoff_q <= holdoff_d;
      pulse_q   <= pulse_d;
    end
  end

  assign wake_o = (pulse_q != '0);

endmodule

// File: rtl/argmax_wake.sv
// rtl/argmax_wake.sv - streaming per-frame argmax over class scores with debounced wake output
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   data_i         : signed class score, one per beat, class 0 first
//   valid_i/ready_o: beat handshake; ready_o drops for one bubble cycle per frame
//   last_i         : final beat of the frame
//   target_class_i : class index counted as a hit
//   class_o        : argmax of the last well-formed frame, held between strobes
//   class_valid_o  : one-cycle strobe when class_o is updated
//   frame_err_o    : one-cycle strobe when a malformed frame is dropped
//   wake_o         : wake pulse from the hit debouncer
module argmax_wake
  import wrd_pkg::*;
#(
  parameter int BW             = 8,
  parameter int NUM_CLASSES    = 3,
  parameter int HIST_LEN       = 4,
  parameter int HIT_THRESH     = 3,
  parameter int WAKE_CYCLES    = 16,
  parameter int HOLDOFF_FRAMES = 8,
  localparam int CLASS_BW      = class_bw(NUM_CLASSES)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic signed [BW-1:0] data_i,
  input  logic                 valid_i,
  input  logic                 last_i,
  output logic                 ready_o,
  input  logic [CLASS_BW-1:0]  target_class_i,
  output logic [CLASS_BW-1:0]  class_o,
  output logic                 class_valid_o,
  output logic                 frame_err_o,
  output logic                 wake_o
);

  localparam int CNT_W = cnt_bw(NUM_CLASSES);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     beat_q, beat_d;
  logic signed [BW-1:0] max_q, max_d, cand_max;
  logic [CLASS_BW-1:0]  idx_q, idx_d, cand_idx;
  logic [CLASS_BW-1:0]  class_q, class_d;
  logic                 good_q, good_d;
  logic                 accept, take;

  assign ready_o = (state_q == ST_ACCUM);
  assign accept  = valid_i && ready_o;

  always_comb begin
    // Beat 0 always loads; later beats only on a strictly greater score so
    // ties keep the lowest index. Beats past the class count are ignored.
    take     = (beat_q == '0) ||
               ((beat_q < CNT_W'(NUM_CLASSES)) && (data_i > max_q));
    cand_max = take ? data_i : max_q;
    cand_idx = take ? CLASS_BW'(beat_q) : idx_q;

    state_d = state_q;
    beat_d  = beat_q;
    max_d   = max_q;
    idx_d   = idx_q;
    class_d = class_q;
    good_d  = good_q;

    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          max_d  = cand_max;
          idx_d  = cand_idx;
          beat_d = (beat_q == CNT_W'(NUM_CLASSES)) ? beat_q : beat_q + CNT_W'(1);
          if (last_i) begin
            state_d = ST_DECIDE;
            good_d  = (beat_q == CNT_W'(NUM_CLASSES - 1));
            // class_o only moves for well-formed frames so it holds otherwise.
            if (beat_q == CNT_W'(NUM_CLASSES - 1)) begin
              class_d = cand_idx;
            end
          end
        end
      end
      ST_DECIDE: begin
        state_d = ST_ACCUM;
        beat_d  = '0;
        good_d  = 1'b0;
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_ACCUM;
      beat_q  <= '0;
      max_q   <= '0;
      idx_q   <= '0;
      class_q <= '0;
      good_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
      class_q <= class_d;
      good_q  <= good_d;
    end
  end

  assign class_o       = class_q;
  assign class_valid_o = (state_q == ST_DECIDE) && good_q;
  assign frame_err_o   = (state_q == ST_DECIDE) && !good_q;

  wake_debounce #(
    .NUM_CLASSES   (NUM_CLASSES),
    .HIST_LEN      (HIST_LEN),
    .HIT_THRESH    (HIT_THRESH),
    .WAKE_CYCLES   (WAKE_CYCLES),
    .HOLDOFF_FRAMES(HOLDOFF_FRAMES)
  ) u_debounce (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .decide_i(class_valid_o),
    .class_i (class_q),
    .target_i(target_class_i),
    .wake_o  (wake_o)
  );

endmodule

// File: tb/tb_argmax_wake.sv
// tb/tb_argmax_wake.sv - scoreboard bench for argmax_wake with directed frames
module tb_argmax_wake;

  logic              clk = 1'b0;
  logic              rst_n;
  logic signed [7:0] data_i;
  logic              valid_i, last_i, ready_o;
  logic [1:0]        target_class_i, class_o;
  logic              class_valid_o, frame_err_o, wake_o;

  always #5 clk = ~clk;

  argmax_wake dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .data_i        (data_i),
    .valid_i       (valid_i),
    .last_i        (last_i),
    .ready_o       (ready_o),
    .target_class_i(target_class_i),
    .class_o       (class_o),
    .class_valid_o (class_valid_o),
    .frame_err_o   (frame_err_o),
    .wake_o        (wake_o)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  int exp_cls_val[$];
  int exp_cls_cyc[$];
  int exp_err_cyc[$];
  int exp_wake_cyc[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT strobes an output.
  logic wake_prev = 1'b0;
  int   wake_len  = 0;
  int   m_v, m_c;

  always @(negedge clk) begin
    if (!rst_n) begin
      wake_prev = 1'b0;
      wake_len  = 0;
    end else begin
      if (class_valid_o) begin
        if (exp_cls_val.size() == 0) chk("unexpected class_valid_o", 1, 0);
        else begin
          m_v = exp_cls_val.pop_front();
          m_c = exp_cls_cyc.pop_front();
          chk("class_o", int'(class_o), m_v);
          chk("class_valid_o cycle", cyc, m_c);
        end
      end
      if (frame_err_o) begin
        if (exp_err_cyc.size() == 0) chk("unexpected frame_err_o", 1, 0);
        else begin
          m_c = exp_err_cyc.pop_front();
          chk("frame_err_o cycle", cyc, m_c);
        end
      end
      if (wake_o && !wake_prev) begin
        if (exp_wake_cyc.size() == 0) chk("unexpected wake_o", 1, 0);
        else begin
          m_c = exp_wake_cyc.pop_front();
          chk("wake_o start cycle", cyc, m_c);
        end
        wake_len = 0;
      end
      if (wake_o) wake_len++;
      if (!wake_o && wake_prev) chk("wake_o length", wake_len, 16);
      wake_prev = wake_o;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // kind 0: well-formed frame with class exp_cls; kind 1: malformed frame.
  task automatic send_frame(input int n, input int sc[4], input int kind,
                            input int exp_cls, input bit exp_wake);
    int t;
    for (int b = 0; b < n; b++) begin
      data_i  = 8'(sc[b]);
      valid_i = 1'b1;
      last_i  = (b == n - 1);
      t = 0;
      while (!ready_o && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!ready_o) chk("ready_o timeout", 0, 1);
      if (b == n - 1) begin
        if (kind == 0) begin
          exp_cls_val.push_back(exp_cls);
          exp_cls_cyc.push_back(cyc + 1);
          if (exp_wake) exp_wake_cyc.push_back(cyc + 2);
        end else begin
          exp_err_cyc.push_back(cyc + 1);
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("reset wake_o", int'(wake_o), 0);
    chk("reset ready_o", int'(ready_o), 1);
    chk("reset class_o", int'(class_o), 0);
    chk("reset class_valid_o", int'(class_valid_o), 0);
    chk("reset frame_err_o", int'(frame_err_o), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    valid_i        = 1'b0;
    last_i         = 1'b0;
    data_i         = '0;
    target_class_i = 2'd1;
    idle(3);
    chk("init ready_o", int'(ready_o), 1);
    chk("init class_o", int'(class_o), 0);
    chk("init class_valid_o", int'(class_valid_o), 0);
    chk("init frame_err_o", int'(frame_err_o), 0);
    chk("init wake_o", int'(wake_o), 0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Basic decode and tie handling; history 1,10,100,1000 never wakes.
    send_frame(3, '{-5, 10, 3, 0}, 0, 1, 1'b0);
    send_frame(3, '{7, 7, -128, 0}, 0, 0, 1'b0);
    send_frame(3, '{-128, -128, -128, 0}, 0, 0, 1'b0);
    send_frame(3, '{1, 2, 3, 0}, 0, 2, 1'b0);
    idle(20);
    apply_reset();

    // hit, miss, hit, hit -> wake on the fourth frame.
    send_frame(3, '{-1, 50, -2, 0}, 0, 1, 1'b0);
    send_frame(3, '{1, 0, 0, 0}, 0, 0, 1'b0);
    send_frame(3, '{-1, 50, -2, 0}, 0, 1, 1'b0);
    send_frame(3, '{-1, 50, -2, 0}, 0, 1, 1'b1);
    // Eight holdoff frames, then three more hits rebuild the history.
    for (int f = 0; f < 11; f++) begin
      send_frame(3, '{-1, 50, -2, 0}, 0, 1, f == 10);
    end
    idle(25);
    apply_reset();

    // Two hits, two malformed frames, then a hit: errors must not shift history.
    send_frame(3, '{0, 9, 1, 0}, 0, 1, 1'b0);
    send_frame(3, '{0, 9, 1, 0}, 0, 1, 1'b0);
    send_frame(2, '{5, 6, 0, 0}, 1, 0, 1'b0);
    send_frame(4, '{1, 2, 3, 4}, 1, 0, 1'b0);
    send_frame(3, '{-3, 4, 4, 0}, 0, 1, 1'b1);

    // Start a frame during the wake pulse, then reset mid-frame and mid-pulse.
    data_i  = 8'sd9;
    valid_i = 1'b1;
    last_i  = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    idle(2);
    chk("wake_o active before reset", int'(wake_o), 1);
    apply_reset();
    chk("wake_o after reset", int'(wake_o), 0);

    send_frame(3, '{3, 2, 1, 0}, 0, 0, 1'b0);
    target_class_i = 2'd2;
    send_frame(3, '{3, 2, 9, 0}, 0, 2, 1'b0);
    target_class_i = 2'd3;
    send_frame(3, '{-7, -8, -9, 0}, 0, 0, 1'b0);
    idle(30);

    chk("pending class expectations", exp_cls_val.size(), 0);
    chk("pending frame_err expectations", exp_err_cyc.size(), 0);
    chk("pending wake expectations", exp_wake_cyc.size(), 0);
    chk("idle wake_o", int'(wake_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
